// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package riscv_fetch_pkg;

   localparam int INST_W  = 32;
   localparam int PC_W    = 64;
   localparam int ENTRY_W = PC_W + INST_W;

   // Fetch sequencer states.
   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_WAIT    = 2'd1,
      ST_DISCARD = 2'd2,
      ST_STOPPED = 2'd3
   } fetch_state_e;

   // Clear the byte offset so every fetch address is word aligned.
   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
      return pc & ~64'd3;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding prefetched {pc, inst} entries.
// Flush has priority over push and pop; the head is presented with no bypass.
module fetch_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   input  logic                       flush,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign full      = (count_r == CW'(DEPTH));
   assign empty     = (count_r == {CW{1'b0}});
   assign do_pop_s  = pop && !empty;
   assign do_push_s = push && (!full || do_pop_s);
   assign rdata     = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
   assign count     = count_r;

   // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
      end
   end

   // Entry storage; contents are only meaningful below the count, so no reset.
   always_ff @(posedge clk) begin
      if (do_push_s && !flush && !reset) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, keeps at most one request in
// flight to instruction memory and buffers responses for the ID stage.
module riscv_fetch_unit
   import riscv_fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   input  logic        halt_fetch,
   output logic        id_valid,
   output logic [31:0] id_inst,
   output logic [63:0] id_pc,
   input  logic        id_ready
);

   localparam int CW = $clog2(DEPTH + 1);

   fetch_state_e      state_r;
   fetch_state_e      state_nxt_s;
   logic [PC_W-1:0]   fpc_r;
   logic [PC_W-1:0]   fpc_nxt_s;
   logic              stop_r;
   logic              stop_nxt_s;
   logic              req_s;
   logic              accept_s;
   logic              push_s;
   logic              pop_s;
   logic              flush_s;
   logic [ENTRY_W-1:0] push_data_s;
   logic [ENTRY_W-1:0] fifo_rdata_s;
   logic [CW-1:0]     fifo_count_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;

   // Request only from RUN while a slot is free; nothing is outstanding in RUN.
   always_comb begin
      req_s = 1'b0;
      if (!reset && (state_r == ST_RUN) && (fifo_count_s < CW'(DEPTH))) begin
         req_s = 1'b1;
      end else begin
         req_s = 1'b0;
      end
   end

   assign imem_req    = req_s;
   assign imem_addr   = reset ? {PC_W{1'b0}} : fpc_r;
   assign accept_s    = req_s && imem_ready;
   assign flush_s     = redirect || halt_fetch;
   assign pop_s       = id_valid && id_ready;
   // fpc already advanced past the outstanding request, so its PC is fpc - 4.
   assign push_data_s = {fpc_r - 64'd4, imem_rdata};

   // Next-state, fetch PC and stop flag; halt outranks redirect, both drop any push.
   always_comb begin
      state_nxt_s = state_r;
      fpc_nxt_s   = fpc_r;
      stop_nxt_s  = stop_r;
      push_s      = 1'b0;
      case (state_r)
         ST_RUN: begin
            if (accept_s) begin
               state_nxt_s = ST_WAIT;
               fpc_nxt_s   = fpc_r + 64'd4;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               push_s      = 1'b1;
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_DISCARD: begin
            if (imem_rvalid) begin
               state_nxt_s = stop_r ? ST_STOPPED : ST_RUN;
            end else begin
               state_nxt_s = ST_DISCARD;
            end
         end
         ST_STOPPED: begin
            state_nxt_s = ST_STOPPED;
         end
         default: begin
            state_nxt_s = ST_RUN;
         end
      endcase

      if (halt_fetch) begin
         stop_nxt_s = 1'b1;
         push_s     = 1'b0;
         case (state_r)
            ST_RUN:     state_nxt_s = accept_s ? ST_DISCARD : ST_STOPPED;
            ST_WAIT:    state_nxt_s = imem_rvalid ? ST_STOPPED : ST_DISCARD;
            ST_DISCARD: state_nxt_s = imem_rvalid ? ST_STOPPED : ST_DISCARD;
            default:    state_nxt_s = ST_STOPPED;
         endcase
      end else if (redirect) begin
         fpc_nxt_s = align_pc(redirect_pc);
         push_s    = 1'b0;
         case (state_r)
            ST_RUN:  state_nxt_s = accept_s ? ST_DISCARD : ST_RUN;
            ST_WAIT: state_nxt_s = imem_rvalid ? ST_RUN : ST_DISCARD;
            default: state_nxt_s = state_nxt_s;
         endcase
      end else begin
         stop_nxt_s = stop_r;
      end
   end

   // Sequencer state, fetch PC and sticky stop flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_RUN;
         fpc_r   <= RESET_PC;
         stop_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         fpc_r   <= fpc_nxt_s;
         stop_r  <= stop_nxt_s;
      end
   end

   fetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_s && !fifo_full_s),
      .wdata (push_data_s),
      .pop   (pop_s),
      .flush (flush_s),
      .rdata (fifo_rdata_s),
      .count (fifo_count_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   assign id_valid = !fifo_empty_s;
   assign id_inst  = fifo_rdata_s[INST_W-1:0];
   assign id_pc    = fifo_rdata_s[ENTRY_W-1:INST_W];

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Self-checking bench for riscv_fetch_unit: a variable-latency memory model
// feeds a scoreboard of expected {pc} entries that the ID side pops and compares.
module tb_riscv_fetch_unit;

   localparam int          DEPTH    = 4;
   localparam logic [63:0] RESET_PC = 64'h0;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic        halt_fetch;
   logic        id_valid;
   logic [31:0] id_inst;
   logic [63:0] id_pc;
   logic        id_ready;

   riscv_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt_fetch  (halt_fetch),
      .id_valid    (id_valid),
      .id_inst     (id_inst),
      .id_pc       (id_pc),
      .id_ready    (id_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] sb [$];
   bit          pend = 1'b0;
   int          pend_cnt = 0;
   logic [63:0] pend_addr = 64'd0;
   bit          pend_stale = 1'b0;
   bit          stopped = 1'b0;
   logic [63:0] exp_fpc = RESET_PC;
   int          lat = 1;
   bit          g_ready = 1'b1;
   bit          g_id_ready = 1'b1;
   bit          g_inj = 1'b0;
   bit          prev_hold = 1'b0;
   logic [63:0] prev_addr = 64'd0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs at negedge, check outputs, then advance the model.
   task automatic step(input bit rst, input bit rdr, input logic [63:0] rpc, input bit hlt);
      bit          rv;
      bit          acc;
      bit          pop;
      bit          flush;
      bit          exp_req;
      logic [63:0] head;
      @(negedge clk);
      reset       = rst;
      redirect    = rdr;
      redirect_pc = rpc;
      halt_fetch  = hlt;
      imem_ready  = g_ready;
      id_ready    = g_id_ready;
      rv          = (pend && (pend_cnt == 0)) || g_inj;
      imem_rvalid = rv;
      imem_rdata  = rv ? (pend ? pend_addr[31:0] : 32'hdead_beef) : 32'h0;
      #1;
      acc = 1'b0;
      pop = 1'b0;
      if (rst) begin
         check_eq("rst_req", {63'd0, imem_req}, 64'd0);
         check_eq("rst_addr", imem_addr, 64'd0);
      end else begin
         exp_req = !pend && !stopped && (sb.size() < DEPTH);
         check_eq("imem_req", {63'd0, imem_req}, {63'd0, exp_req});
         if (imem_req) check_eq("imem_addr", imem_addr, exp_fpc);
         if (prev_hold) check_eq("addr_hold", imem_addr, prev_addr);
         check_eq("id_valid", {63'd0, id_valid}, {63'd0, sb.size() != 0});
         if (id_valid && (sb.size() != 0)) begin
            head = sb[0];
            check_eq("id_pc", id_pc, head);
            check_eq("id_inst", {32'd0, id_inst}, {32'd0, head[31:0]});
         end
         acc = imem_req && imem_ready;
         pop = id_valid && id_ready;
      end
      flush     = rdr || hlt;
      prev_hold = !rst && imem_req && !imem_ready && !flush;
      prev_addr = imem_addr;
      if (rst) begin
         sb.delete();
         pend    = 1'b0;
         stopped = 1'b0;
         exp_fpc = RESET_PC;
      end else begin
         if (pop && (sb.size() != 0)) void'(sb.pop_front());
         if (pend) begin
            if (pend_cnt == 0) begin
               if (!pend_stale && !flush) sb.push_back(pend_addr);
               pend = 1'b0;
            end else begin
               pend_cnt--;
            end
         end
         if (acc) begin
            pend       = 1'b1;
            pend_cnt   = lat - 1;
            pend_addr  = imem_addr;
            pend_stale = 1'b0;
            exp_fpc    = exp_fpc + 64'd4;
         end
         if (flush) begin
            sb.delete();
            pend_stale = 1'b1;
            if (hlt) stopped = 1'b1;
            else     exp_fpc = {rpc[63:2], 2'b00};
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 64'd0, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 64'd0, 1'b0);
      step(1'b1, 1'b0, 64'd0, 1'b0);
   endtask

   initial begin
      reset = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
      redirect = 1'b0; redirect_pc = 64'd0; halt_fetch = 1'b0; id_ready = 1'b0;

      // 1: latency-1 memory, ID always ready.
      lat = 1; g_ready = 1'b1; g_id_ready = 1'b1;
      do_reset();
      run(20);

      // 2: ID stalled from reset fills the queue, then drains.
      g_id_ready = 1'b0;
      do_reset();
      run(20);
      g_id_ready = 1'b1;
      run(15);

      // 3: latency-3, redirect while a request is in flight.
      lat = 3;
      do_reset();
      for (int i = 0; i < 20 && !pend; i++) run(1);
      check_eq("t3_wait_pend", {63'd0, pend}, 64'd1);
      step(1'b0, 1'b1, 64'h103, 1'b0);
      run(20);

      // 4: redirect coincident with rvalid and a pop.
      g_id_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 40 && !(pend && pend_cnt == 0 && sb.size() > 0); i++) run(1);
      check_eq("t4_wait_cond", {63'd0, pend && (pend_cnt == 0) && (sb.size() > 0)}, 64'd1);
      g_id_ready = 1'b1;
      step(1'b0, 1'b1, 64'h200, 1'b0);
      run(20);

      // 5: memory not ready for 3 cycles, redirect on the second.
      lat = 1;
      do_reset();
      g_ready = 1'b0;
      run(1);
      step(1'b0, 1'b1, 64'h300, 1'b0);
      run(1);
      g_ready = 1'b1;
      run(12);

      // 6: halt in WAIT, stay quiet, spurious rvalid ignored, then reset restarts.
      lat = 3;
      do_reset();
      for (int i = 0; i < 20 && !pend; i++) run(1);
      check_eq("t6_wait_pend", {63'd0, pend}, 64'd1);
      step(1'b0, 1'b0, 64'd0, 1'b1);
      run(10);
      g_inj = 1'b1;
      run(1);
      g_inj = 1'b0;
      run(9);
      step(1'b1, 1'b0, 64'd0, 1'b0);
      run(16);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
